// File: rtl/data_cache.sv
// Direct-mapped, one-word-per-line, write-through/write-allocate data cache.
// Optional hit/miss counters are enabled by defining DATA_CACHE_STATS_EN.
module data_cache #(
  parameter int LINES = 16
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [31:0]     cpu_addr,
  input  logic [0:3][7:0] cpu_wdata,
  output logic [0:3][7:0] cpu_rdata,
  output logic            cpu_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [0:3][7:0] mem_wdata,
  input  logic [0:3][7:0] mem_rdata,
  input  logic            mem_ack
`ifdef DATA_CACHE_STATS_EN
  ,
  output logic [31:0]     hit_count,
  output logic [31:0]     miss_count
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t          state_reg;
  logic            mem_req_reg;
  logic            mem_we_reg;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic            hit;
  logic            ack;
  logic            line_we;
  logic [0:3][7:0] line_data;
  logic            unused_addr_bits;

  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [0:3][7:0]  data_mem [LINES];
  logic [LINES-1:0] valid_reg;

  assign idx = cpu_addr[2 +: IDX_W];
  assign tag = cpu_addr[31 -: TAG_W];
  assign unused_addr_bits = ^cpu_addr[1:0];

  assign hit = valid_reg[idx] && (tag_mem[idx] == tag);
  assign ack = mem_req_reg && mem_ack;

  // A reset coinciding with the ack aborts the transfer, so the line is left untouched.
  assign line_we   = rst_b && ack;
  assign line_data = (state_reg == WRITE) ? cpu_wdata : mem_rdata;

  assign cpu_rdata = data_mem[idx];
  assign cpu_ready = rst_b && cpu_req &&
                     (((state_reg == IDLE) && !cpu_we && hit) ||
                      ((state_reg == WRITE) && ack));

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = {cpu_addr[31:2], 2'b00};
  assign mem_wdata = cpu_wdata;

  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= line_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_valid
      always_ff @(posedge clk) begin
        if (!rst_b) begin
          valid_reg[gi] <= 1'b0;
        end else if (line_we && (idx == IDX_W'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_reg   <= IDLE;
      mem_req_reg <= 1'b0;
      mem_we_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cpu_req && cpu_we) begin
            state_reg   <= WRITE;
            mem_req_reg <= 1'b1;
            mem_we_reg  <= 1'b1;
          end else if (cpu_req && !hit) begin
            state_reg   <= REFILL;
            mem_req_reg <= 1'b1;
            mem_we_reg  <= 1'b0;
          end
        end
        REFILL, WRITE: begin
          if (mem_ack) begin
            state_reg   <= IDLE;
            mem_req_reg <= 1'b0;
            mem_we_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg   <= IDLE;
          mem_req_reg <= 1'b0;
          mem_we_reg  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DATA_CACHE_STATS_EN
  logic [31:0] hit_count_reg;
  logic [31:0] miss_count_reg;
  logic        retry_reg;

  assign hit_count  = hit_count_reg;
  assign miss_count = miss_count_reg;

  // retry_reg marks the post-refill lookup so it is not counted as a hit.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
      retry_reg      <= 1'b0;
    end else begin
      if ((state_reg == IDLE) && cpu_req && !cpu_we) begin
        if (hit) begin
          if (!retry_reg && (hit_count_reg != 32'hFFFF_FFFF)) begin
            hit_count_reg <= hit_count_reg + 32'd1;
          end
          retry_reg <= 1'b0;
        end else if (miss_count_reg != 32'hFFFF_FFFF) begin
          miss_count_reg <= miss_count_reg + 32'd1;
        end
      end
      if ((state_reg == REFILL) && mem_ack) begin
        retry_reg <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_cache.sv
// Randomized bench for data_cache against a direct-mapped cache / flat memory model.
module tb_data_cache;

  localparam int LINES = 16;

  logic            clk;
  logic            rst_b;
  logic            cpu_req;
  logic            cpu_we;
  logic [31:0]     cpu_addr;
  logic [0:3][7:0] cpu_wdata;
  logic [0:3][7:0] cpu_rdata;
  logic            cpu_ready;
  logic            mem_req;
  logic            mem_we;
  logic [31:0]     mem_addr;
  logic [0:3][7:0] mem_wdata;
  logic [0:3][7:0] mem_rdata;
  logic            mem_ack;
`ifdef DATA_CACHE_STATS_EN
  logic [31:0]     hit_count;
  logic [31:0]     miss_count;
`endif

  data_cache #(.LINES(LINES)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef DATA_CACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: backing memory by word address, and which word each line holds.
  logic [31:0] mem_model [logic [29:0]];
  logic [29:0] line_word [LINES];
  bit          line_v    [LINES];
  int          exp_hits  = 0;
  int          exp_miss  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [29:0] wa;
    wa = addr[31:2];
    if (mem_model.exists(wa)) return mem_model[wa];
    return ({2'b00, wa} * 32'h9E37_79B1) + 32'h0123_4567;
  endfunction

  function automatic bit model_hit(input logic [31:0] addr);
    int li;
    li = int'(addr[31:2] % LINES);
    return line_v[li] && (line_word[li] == addr[31:2]);
  endfunction

  function automatic void model_fill(input logic [31:0] addr);
    int li;
    li = int'(addr[31:2] % LINES);
    line_v[li]    = 1'b1;
    line_word[li] = addr[31:2];
  endfunction

  function automatic void model_flush();
    for (int i = 0; i < LINES; i++) line_v[i] = 1'b0;
    exp_hits = 0;
    exp_miss = 0;
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_read(input logic [31:0] addr, input int dly);
    bit hit;
    hit = model_hit(addr);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = addr;
    @(negedge clk);
    check("rd_first_ready", {63'd0, cpu_ready}, {63'd0, hit});
    if (hit) begin
      exp_hits++;
    end else begin
      exp_miss++;
      @(posedge clk); #1;
      for (int c = 0; c <= dly; c++) begin
        mem_ack   = (c == dly);
        mem_rdata = mem_word(addr);
        @(negedge clk);
        check("rf_mem_req", {63'd0, mem_req}, 64'd1);
        check("rf_mem_we", {63'd0, mem_we}, 64'd0);
        check("rf_mem_addr", {32'd0, mem_addr}, {32'd0, addr[31:2], 2'b00});
        check("rf_no_ready", {63'd0, cpu_ready}, 64'd0);
        @(posedge clk); #1;
      end
      mem_ack = 1'b0;
      model_fill(addr);
      @(negedge clk);
      check("rd_retry_ready", {63'd0, cpu_ready}, 64'd1);
    end
    check("rd_data", {32'd0, cpu_rdata}, {32'd0, mem_word(addr)});
    check("rd_idle_mem_req", {63'd0, mem_req}, 64'd0);
    $display("read  addr=%08h hit=%0d dly=%0d data=%08h", addr, hit, dly, cpu_rdata);
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int dly);
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = addr;
    cpu_wdata = data;
    @(negedge clk);
    check("wr_first_ready", {63'd0, cpu_ready}, 64'd0);
    @(posedge clk); #1;
    for (int c = 0; c <= dly; c++) begin
      mem_ack = (c == dly);
      @(negedge clk);
      check("wr_mem_req", {63'd0, mem_req}, 64'd1);
      check("wr_mem_we", {63'd0, mem_we}, 64'd1);
      check("wr_mem_addr", {32'd0, mem_addr}, {32'd0, addr[31:2], 2'b00});
      check("wr_mem_wdata", {32'd0, mem_wdata}, {32'd0, data});
      check("wr_ready", {63'd0, cpu_ready}, {63'd0, (c == dly)});
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    cpu_req = 1'b0;
    mem_model[addr[31:2]] = data;
    model_fill(addr);
    $display("write addr=%08h data=%08h dly=%0d", addr, data, dly);
  endtask

  task automatic do_idle();
    cpu_req = 1'b0;
    cpu_we  = $urandom_range(0, 1);
    @(negedge clk);
    check("idle_ready", {63'd0, cpu_ready}, 64'd0);
    check("idle_mem_req", {63'd0, mem_req}, 64'd0);
    $display("idle");
    @(posedge clk); #1;
  endtask

  // Reset lands in the second REFILL cycle together with a mem_ack.
  task automatic do_reset_abort(input logic [31:0] addr);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = addr;
    @(negedge clk);
    check("ab_first_ready", {63'd0, cpu_ready}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("ab_mem_req_c1", {63'd0, mem_req}, 64'd1);
    @(posedge clk); #1;
    rst_b     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = mem_word(addr);
    @(posedge clk); #1;
    rst_b   = 1'b1;
    mem_ack = 1'b0;
    cpu_req = 1'b0;
    model_flush();
    @(negedge clk);
    check("ab_mem_req_after", {63'd0, mem_req}, 64'd0);
    check("ab_ready_after", {63'd0, cpu_ready}, 64'd0);
    $display("abort addr=%08h by reset in refill", addr);
    @(posedge clk); #1;
  endtask

`ifdef DATA_CACHE_STATS_EN
  task automatic check_stats(input string tag);
    check({tag, "_hits"}, {32'd0, hit_count}, 64'(exp_hits));
    check({tag, "_miss"}, {32'd0, miss_count}, 64'(exp_miss));
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    rst_b     = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    model_flush();
    repeat (3) @(posedge clk);
    #1;
    rst_b = 1'b1;
    @(negedge clk);
    check("rst_ready", {63'd0, cpu_ready}, 64'd0);
    check("rst_mem_req", {63'd0, mem_req}, 64'd0);
`ifdef DATA_CACHE_STATS_EN
    check_stats("rst");
`endif
    @(posedge clk); #1;

    mem_model[30'h10] = 32'h1122_3344;
    do_read(32'h0000_0040, 3);
    check("dir_first_miss_state", {63'd0, model_hit(32'h40)}, 64'd1);
    do_read(32'h0000_0040, 0);
    do_write(32'h0000_0044, 32'hAABB_CCDD, 0);
    do_read(32'h0000_0044, 0);
    do_read(32'h0000_0080, 1);
    do_read(32'h0000_0040, 2);
    do_read(32'h0000_0043, 0);
    do_reset_abort(32'h0000_0200);
    do_read(32'h0000_0200, 1);

    do_reset_abort(32'h0000_0048);
    do_read(32'h0000_0048, 0);
    do_read(32'h0000_0048, 0);
    do_read(32'h0000_004A, 0);
    do_read(32'h0000_0049, 0);
`ifdef DATA_CACHE_STATS_EN
    check_stats("dir");
`endif

    for (int t = 0; t < 300; t++) begin
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) a[31] = 1'b1;
      d = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2: do_write(a, d, $urandom_range(0, 3));
        3:       do_idle();
        default: do_read(a, $urandom_range(0, 4));
      endcase
    end
`ifdef DATA_CACHE_STATS_EN
    check_stats("end");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
